// File: rtl/w_seq_ctrl_pkg.sv
// Shared definitions for the weight-streaming sequencer: layer IDs, tag struct,
// FSM encoding and per-layer shape helpers.
package w_seq_ctrl_pkg;

    localparam int IDX_W = 4;

    localparam logic [1:0] L_G2 = 2'd0;
    localparam logic [1:0] L_G3 = 2'd1;
    localparam logic [1:0] L_D2 = 2'd2;
    localparam logic [1:0] L_D3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]       layer;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } w_idx_t;

    // Neurons per layer.
    function automatic logic [IDX_W-1:0] layer_rows(input logic [1:0] layer,
                                                    input int n_g_l2, input int n_g_l3,
                                                    input int n_d_l2, input int n_d_l3);
        logic [IDX_W-1:0] r;
        case (layer)
            L_G2:    r = IDX_W'(n_g_l2);
            L_G3:    r = IDX_W'(n_g_l3);
            L_D2:    r = IDX_W'(n_d_l2);
            default: r = IDX_W'(n_d_l3);
        endcase
        return r;
    endfunction

    // Inputs per neuron: each layer consumes the previous layer's outputs.
    function automatic logic [IDX_W-1:0] layer_cols(input logic [1:0] layer,
                                                    input int n_input, input int n_g_l2,
                                                    input int n_g_l3, input int n_d_l2);
        logic [IDX_W-1:0] c;
        case (layer)
            L_G2:    c = IDX_W'(n_input);
            L_G3:    c = IDX_W'(n_g_l2);
            L_D2:    c = IDX_W'(n_g_l3);
            default: c = IDX_W'(n_d_l2);
        endcase
        return c;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/w_seq_ctrl_if.sv
// Tagged weight-word stream between the sequencer (master) and the MAC array (slave).
interface w_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                                 w_valid;
    logic                                 w_ready;
    logic [WIDTH-1:0]                     w_data;
    logic [1:0]                           w_layer;
    logic [w_seq_ctrl_pkg::IDX_W-1:0]     w_row;
    logic [w_seq_ctrl_pkg::IDX_W-1:0]     w_col;
    logic                                 w_last_col;
    logic                                 w_last;

    modport master (
        output w_valid, w_data, w_layer, w_row, w_col, w_last_col, w_last,
        input  w_ready
    );

    modport slave (
        input  w_valid, w_data, w_layer, w_row, w_col, w_last_col, w_last,
        output w_ready
    );
endinterface

// File: rtl/w_seq_ctrl_word_sel.sv
// Combinational word selector: picks the layer bus, then the word at row*cols+col.
module w_word_sel
    import w_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_INPUT = 2,
    parameter int N_G_L2  = 3,
    parameter int N_G_L3  = 9,
    parameter int N_D_L2  = 3,
    parameter int N_D_L3  = 1
) (
    input  logic [N_INPUT*N_G_L2*WIDTH-1:0] wg2,
    input  logic [N_G_L2*N_G_L3*WIDTH-1:0]  wg3,
    input  logic [N_G_L3*N_D_L2*WIDTH-1:0]  wd2,
    input  logic [N_D_L2*N_D_L3*WIDTH-1:0]  wd3,
    input  w_idx_t                          sel,
    output logic [WIDTH-1:0]                word
);

    localparam int G2_N   = N_INPUT * N_G_L2;
    localparam int G3_N   = N_G_L2 * N_G_L3;
    localparam int D2_N   = N_G_L3 * N_D_L2;
    localparam int D3_N   = N_D_L2 * N_D_L3;
    localparam int G2_AW  = addr_bits(G2_N);
    localparam int G3_AW  = addr_bits(G3_N);
    localparam int D2_AW  = addr_bits(D2_N);
    localparam int D3_AW  = addr_bits(D3_N);
    localparam int FLAT_W = max_int(max_int(G2_AW, G3_AW), max_int(D2_AW, D3_AW));

    logic [WIDTH-1:0] g2_w [G2_N];
    logic [WIDTH-1:0] g3_w [G3_N];
    logic [WIDTH-1:0] d2_w [D2_N];
    logic [WIDTH-1:0] d3_w [D3_N];

    genvar gi;
    generate
        for (gi = 0; gi < G2_N; gi++) begin : g_g2
            assign g2_w[gi] = wg2[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < G3_N; gi++) begin : g_g3
            assign g3_w[gi] = wg3[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < D2_N; gi++) begin : g_d2
            assign d2_w[gi] = wd2[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < D3_N; gi++) begin : g_d3
            assign d3_w[gi] = wd3[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [IDX_W-1:0]  cols;
    logic [FLAT_W-1:0] flat;

    always_comb begin
        word = '0;
        cols = layer_cols(sel.layer, N_INPUT, N_G_L2, N_G_L3, N_D_L2);
        // row and col are always in range, so the flat index fits the layer's array.
        flat = FLAT_W'({{IDX_W{1'b0}}, sel.row} * {{IDX_W{1'b0}}, cols}
                       + {{IDX_W{1'b0}}, sel.col});
        case (sel.layer)
            L_G2:    word = g2_w[flat[G2_AW-1:0]];
            L_G3:    word = g3_w[flat[G3_AW-1:0]];
            L_D2:    word = d2_w[flat[D2_AW-1:0]];
            default: word = d3_w[flat[D3_AW-1:0]];
        endcase
    end

endmodule

// File: rtl/w_seq_ctrl.sv
// Weight-streaming sequencer: latches the set selection on start, then streams all
// G2/G3/D2/D3 weight words with layer/row/col tags over a valid/ready channel.
module w_seq_ctrl
    import w_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_INPUT = 2,
    parameter int N_G_L2  = 3,
    parameter int N_G_L3  = 9,
    parameter int N_D_L2  = 3,
    parameter int N_D_L3  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [3:0]                      cfg_choice,
    output logic [3:0]                      choice,
    input  logic [N_INPUT*N_G_L2*WIDTH-1:0] wg2,
    input  logic [N_G_L2*N_G_L3*WIDTH-1:0]  wg3,
    input  logic [N_G_L3*N_D_L2*WIDTH-1:0]  wd2,
    input  logic [N_D_L2*N_D_L3*WIDTH-1:0]  wd3,
    output logic                            busy,
    output logic                            done,
    w_seq_ctrl_if.master                    w
);

    state_t           state_reg, state_next;
    logic [3:0]       choice_reg, choice_next;
    w_idx_t           idx_reg, idx_next;
    logic [WIDTH-1:0] w_data_reg, w_data_next;
    logic             w_valid_reg, w_valid_next;
    logic             w_last_col_reg, w_last_col_next;
    logic             w_last_reg, w_last_next;

    logic [IDX_W-1:0] cur_rows, cur_cols;
    logic [IDX_W-1:0] fetch_rows, fetch_cols;
    w_idx_t           adv_idx, fetch_idx;
    logic             fetch_last_col, fetch_last;
    logic [WIDTH-1:0] fetch_word;
    logic             handshake;

    w_word_sel #(
        .WIDTH   (WIDTH),
        .N_INPUT (N_INPUT),
        .N_G_L2  (N_G_L2),
        .N_G_L3  (N_G_L3),
        .N_D_L2  (N_D_L2),
        .N_D_L3  (N_D_L3)
    ) u_word_sel (
        .wg2  (wg2),
        .wg3  (wg3),
        .wd2  (wd2),
        .wd3  (wd3),
        .sel  (fetch_idx),
        .word (fetch_word)
    );

    // Index of the word to load next: origin in LOAD, successor of the current word otherwise.
    always_comb begin
        cur_rows = layer_rows(idx_reg.layer, N_G_L2, N_G_L3, N_D_L2, N_D_L3);
        cur_cols = layer_cols(idx_reg.layer, N_INPUT, N_G_L2, N_G_L3, N_D_L2);
        adv_idx  = idx_reg;
        if (idx_reg.col == cur_cols - 1'b1) begin
            adv_idx.col = '0;
            if (idx_reg.row == cur_rows - 1'b1) begin
                adv_idx.row   = '0;
                adv_idx.layer = idx_reg.layer + 1'b1;
            end else begin
                adv_idx.row = idx_reg.row + 1'b1;
            end
        end else begin
            adv_idx.col = idx_reg.col + 1'b1;
        end

        fetch_idx      = (state_reg == ST_LOAD) ? '0 : adv_idx;
        fetch_rows     = layer_rows(fetch_idx.layer, N_G_L2, N_G_L3, N_D_L2, N_D_L3);
        fetch_cols     = layer_cols(fetch_idx.layer, N_INPUT, N_G_L2, N_G_L3, N_D_L2);
        fetch_last_col = (fetch_idx.col == fetch_cols - 1'b1);
        fetch_last     = fetch_last_col && (fetch_idx.row == fetch_rows - 1'b1)
                         && (fetch_idx.layer == L_D3);
    end

    assign handshake = w_valid_reg && w.w_ready;

    always_comb begin
        state_next      = state_reg;
        choice_next     = choice_reg;
        idx_next        = idx_reg;
        w_data_next     = w_data_reg;
        w_valid_next    = w_valid_reg;
        w_last_col_next = w_last_col_reg;
        w_last_next     = w_last_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    choice_next = cfg_choice;
                    state_next  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_next        = fetch_idx;
                w_data_next     = fetch_word;
                w_last_col_next = fetch_last_col;
                w_last_next     = fetch_last;
                w_valid_next    = 1'b1;
                state_next      = ST_STREAM;
            end
            ST_STREAM: begin
                if (handshake) begin
                    if (w_last_reg) begin
                        // Stream complete: return the channel to its quiet state.
                        idx_next        = '0;
                        w_data_next     = '0;
                        w_last_col_next = 1'b0;
                        w_last_next     = 1'b0;
                        w_valid_next    = 1'b0;
                        state_next      = ST_DONE;
                    end else begin
                        idx_next        = fetch_idx;
                        w_data_next     = fetch_word;
                        w_last_col_next = fetch_last_col;
                        w_last_next     = fetch_last;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            choice_reg     <= '0;
            idx_reg        <= '0;
            w_data_reg     <= '0;
            w_valid_reg    <= 1'b0;
            w_last_col_reg <= 1'b0;
            w_last_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            choice_reg     <= choice_next;
            idx_reg        <= idx_next;
            w_data_reg     <= w_data_next;
            w_valid_reg    <= w_valid_next;
            w_last_col_reg <= w_last_col_next;
            w_last_reg     <= w_last_next;
        end
    end

    assign choice       = choice_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);
    assign w.w_valid    = w_valid_reg;
    assign w.w_data     = w_data_reg;
    assign w.w_layer    = idx_reg.layer;
    assign w.w_row      = idx_reg.row;
    assign w.w_col      = idx_reg.col;
    assign w.w_last_col = w_last_col_reg;
    assign w.w_last     = w_last_reg;

endmodule

// File: tb/tb_w_seq_ctrl.sv
// Directed bench for w_seq_ctrl: weight-memory model, stream scoreboard and
// cycle-exact checks of data, tags, backpressure, ignored starts and reset abort.
module tb_w_seq_ctrl;

    logic              clk;
    logic              rst;
    logic              start;
    logic [3:0]        cfg_choice;
    logic [3:0]        choice;
    logic [2*3*32-1:0] wg2;
    logic [3*9*32-1:0] wg3;
    logic [9*3*32-1:0] wd2;
    logic [3*1*32-1:0] wd3;
    logic              busy;
    logic              done;

    w_seq_ctrl_if #(.WIDTH(32)) w_if ();

    w_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_choice (cfg_choice),
        .choice     (choice),
        .wg2        (wg2),
        .wg3        (wg3),
        .wd2        (wd2),
        .wd3        (wd3),
        .busy       (busy),
        .done       (done),
        .w          (w_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int ROWS [4] = '{3, 9, 3, 1};
    localparam int COLS [4] = '{2, 3, 9, 3};

    // Weight memory contents: two sets per layer, a few words fixed to known values.
    function automatic logic [31:0] mem_word(input int l, input int s, input int i);
        if (l == 0 && s == 0 && i == 0) return 32'hFFFF1337;
        if (l == 0 && s == 0 && i == 1) return 32'h0003B169;
        if (l == 1 && s == 0 && i == 0) return 32'h00A48E60;
        if (l == 3 && s == 0 && i == 2) return 32'h015376DF;
        if (l == 0 && s == 1 && i == 0) return 32'h00031B20;
        if (l == 2 && s == 1 && i == 0) return 32'hFFE5178C;
        return {8'(l), 8'(s), 8'h5A, 8'(i)};
    endfunction

    always_comb begin
        wg2 = '0;
        wg3 = '0;
        wd2 = '0;
        wd3 = '0;
        for (int i = 0; i < 6; i++)  wg2[i*32 +: 32] = mem_word(0, int'(choice[0]), i);
        for (int i = 0; i < 27; i++) wg3[i*32 +: 32] = mem_word(1, int'(choice[1]), i);
        for (int i = 0; i < 27; i++) wd2[i*32 +: 32] = mem_word(2, int'(choice[2]), i);
        for (int i = 0; i < 3; i++)  wd3[i*32 +: 32] = mem_word(3, int'(choice[3]), i);
    end

    // Scoreboard: its own position counters, compared on every handshake.
    logic [3:0] exp_choice;
    int exp_l, exp_r, exp_c;
    int hs_cnt, done_cnt, model_err;

    initial begin
        exp_l = 0; exp_r = 0; exp_c = 0;
        hs_cnt = 0; done_cnt = 0; model_err = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_l <= 0;
            exp_r <= 0;
            exp_c <= 0;
        end else begin
            if (w_if.w_valid && w_if.w_ready) begin
                $display("xfer %0d: layer=%0d row=%0d col=%0d data=%08h last_col=%0b last=%0b",
                         hs_cnt, w_if.w_layer, w_if.w_row, w_if.w_col, w_if.w_data,
                         w_if.w_last_col, w_if.w_last);
                if (w_if.w_data !== mem_word(exp_l, int'(exp_choice[exp_l]), exp_r*COLS[exp_l] + exp_c)
                    || int'(w_if.w_layer) != exp_l || int'(w_if.w_row) != exp_r
                    || int'(w_if.w_col) != exp_c
                    || w_if.w_last_col !== (exp_c == COLS[exp_l]-1)
                    || w_if.w_last !== (exp_l == 3 && exp_r == ROWS[3]-1 && exp_c == COLS[3]-1))
                    model_err <= model_err + 1;
                hs_cnt <= hs_cnt + 1;
                if (exp_c == COLS[exp_l]-1) begin
                    exp_c <= 0;
                    if (exp_r == ROWS[exp_l]-1) begin
                        exp_r <= 0;
                        exp_l <= (exp_l == 3) ? 0 : exp_l + 1;
                    end else begin
                        exp_r <= exp_r + 1;
                    end
                end else begin
                    exp_c <= exp_c + 1;
                end
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_base, done_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h, required %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // Issue start; on return we are in cycle 1 (LOAD).
    task automatic begin_run(input logic [3:0] cfg);
        cfg_choice = cfg;
        exp_choice = cfg;
        hs_base    = hs_cnt;
        done_base  = done_cnt;
        start      = 1'b1;
        step();
        start      = 1'b0;
        cyc        = 1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_choice = 4'h0;
        exp_choice = 4'h0;
        w_if.w_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(w_if.w_valid), 32'd0);
        chk("rst_data", w_if.w_data, 32'd0);
        chk("rst_choice", 32'(choice), 32'd0);
        chk("rst_last", 32'(w_if.w_last), 32'd0);

        // Run 1: choice 0, ready high, extra starts during STREAM and DONE
        begin_run(4'b0000);
        chk("r1_c1_busy", 32'(busy), 32'd1);
        chk("r1_c1_valid", 32'(w_if.w_valid), 32'd0);
        step();
        chk("r1_w0_valid", 32'(w_if.w_valid), 32'd1);
        chk("r1_w0_data", w_if.w_data, 32'hFFFF1337);
        chk("r1_w0_tags", {w_if.w_layer, w_if.w_row, w_if.w_col}, 32'd0);
        chk("r1_w0_lastcol", 32'(w_if.w_last_col), 32'd0);
        step();
        chk("r1_w1_data", w_if.w_data, 32'h0003B169);
        chk("r1_g2_r0c1_lastcol", 32'(w_if.w_last_col), 32'd1);
        step_to(8);
        chk("r1_w6_data", w_if.w_data, 32'h00A48E60);
        chk("r1_w6_layer", 32'(w_if.w_layer), 32'd1);
        step_to(20);
        start = 1'b1;
        step();
        start = 1'b0;
        step_to(34);
        chk("r1_g3_r8c2_tags", {w_if.w_layer, w_if.w_row, w_if.w_col}, {22'd0, 2'd1, 4'd8, 4'd2});
        step();
        chk("r1_d2_r0c0_tags", {w_if.w_layer, w_if.w_row, w_if.w_col}, {22'd0, 2'd2, 4'd0, 4'd0});
        step_to(61);
        chk("r1_d2_r2c8_tags", {w_if.w_layer, w_if.w_row, w_if.w_col}, {22'd0, 2'd2, 4'd2, 4'd8});
        chk("r1_d2_r2c8_lastcol", 32'(w_if.w_last_col), 32'd1);
        chk("r1_w59_last", 32'(w_if.w_last), 32'd0);
        step_to(64);
        chk("r1_w62_data", w_if.w_data, 32'h015376DF);
        chk("r1_w62_last", 32'(w_if.w_last), 32'd1);
        step();
        chk("r1_c65_done", 32'(done), 32'd1);
        chk("r1_c65_valid", 32'(w_if.w_valid), 32'd0);
        chk("r1_c65_busy", 32'(busy), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("r1_c66_done", 32'(done), 32'd0);
        chk("r1_c66_busy", 32'(busy), 32'd0);
        step();
        chk("r1_c67_busy", 32'(busy), 32'd0);
        chk("r1_handshakes", 32'(hs_cnt - hs_base), 32'd63);
        chk("r1_done_pulses", 32'(done_cnt - done_base), 32'd1);
        chk("r1_model_errs", 32'(model_err), 32'd0);

        // Run 2: mixed set selection 0101
        begin_run(4'b0101);
        chk("r2_choice", 32'(choice), 32'h5);
        step();
        chk("r2_g2_w0", w_if.w_data, 32'h00031B20);
        step_to(8);
        chk("r2_g3_w0", w_if.w_data, 32'h00A48E60);
        step_to(10);
        cfg_choice = 4'hF;
        step_to(35);
        chk("r2_d2_w0", w_if.w_data, 32'hFFE5178C);
        chk("r2_choice_hold", 32'(choice), 32'h5);
        step_to(64);
        chk("r2_d3_w2", w_if.w_data, 32'h015376DF);
        step_to(67);
        chk("r2_choice_idle", 32'(choice), 32'h5);
        chk("r2_handshakes", 32'(hs_cnt - hs_base), 32'd63);
        chk("r2_model_errs", 32'(model_err), 32'd0);

        // Run 3: backpressure on word 1 for three cycles
        begin_run(4'b0000);
        step_to(3);
        w_if.w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("r3_stall_data", w_if.w_data, 32'h0003B169);
            chk("r3_stall_valid", 32'(w_if.w_valid), 32'd1);
            step();
        end
        w_if.w_ready = 1'b1;
        chk("r3_resume_data", w_if.w_data, 32'h0003B169);
        step_to(67);
        chk("r3_c67_done", 32'(done), 32'd0);
        step();
        chk("r3_c68_done", 32'(done), 32'd1);
        step();
        chk("r3_handshakes", 32'(hs_cnt - hs_base), 32'd63);
        chk("r3_model_errs", 32'(model_err), 32'd0);

        // Run 4: reset after word 10, then a fresh stream
        begin_run(4'b0101);
        step_to(12);
        chk("r4_w10_data", w_if.w_data, 32'h01005A04);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r4_abort_valid", 32'(w_if.w_valid), 32'd0);
        chk("r4_abort_data", w_if.w_data, 32'd0);
        chk("r4_abort_tags", {w_if.w_layer, w_if.w_row, w_if.w_col}, 32'd0);
        chk("r4_abort_flags", {w_if.w_last_col, w_if.w_last}, 32'd0);
        chk("r4_abort_busy", 32'(busy), 32'd0);
        chk("r4_abort_done", 32'(done), 32'd0);
        chk("r4_abort_choice", 32'(choice), 32'd0);
        step();
        chk("r4_no_done", 32'(done_cnt - done_base), 32'd0);
        begin_run(4'b0000);
        step();
        chk("r4_restart_w0", w_if.w_data, 32'hFFFF1337);
        chk("r4_restart_tags", {w_if.w_layer, w_if.w_row, w_if.w_col}, 32'd0);
        step_to(65);
        chk("r4_restart_done", 32'(done), 32'd1);
        step();
        chk("r4_handshakes", 32'(hs_cnt - hs_base), 32'd63);
        chk("r4_model_errs", 32'(model_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
